lc3_mem_ctrl: RTL

// - Memory-access stage directly below lc3_control: turns the controller's wait-state requests into bus cycles and returns memRDY.
// - Takes the datapath's MAR/MDR, runs one read or write per request on a variable-latency external bus, and reports completion.
// - Optionally decodes the LC-3 memory-mapped device registers locally.

---
 rtl/lc3_mem_ctrl_pkg.sv | 22 ++
 rtl/lc3_mmio_regs.sv | 71 +++++++
 rtl/lc3_mem_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/lc3_mem_ctrl_pkg.sv
// Shared types and memory-map constants for the LC-3 memory-access stage.
package lc3_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StLocal,
    StDone
  } mem_ctrl_states_e;

  localparam logic [15:0] MMIO_BASE = 16'hFE00;
  localparam logic [15:0] MMIO_LAST = 16'hFE06;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  function automatic logic is_mmio(input logic [15:0] addr);
    return (addr >= MMIO_BASE) && (addr <= MMIO_LAST);
  endfunction

endpackage

// File: rtl/lc3_mmio_regs.sv
// LC-3 keyboard/display device registers, decoded locally by lc3_mem_ctrl.
// Only built when LC3_MMIO_EN is defined.
`ifdef LC3_MMIO_EN
module lc3_mmio_regs
  import lc3_mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        access_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  input  logic        kbd_valid_i,
  input  logic [7:0]  kbd_data_i,
  input  logic        dsp_ready_i,
  output logic [15:0] rdata_o,
  output logic        kbd_irq_o,
  output logic        dsp_valid_o,
  output logic [7:0]  dsp_data_o
);

  logic       ready_q, ready_d;
  logic       ie_q, ie_d;
  logic [7:0] kbd_data_q, kbd_data_d;
  logic       ddr_wr;

  assign ddr_wr = access_i && we_i && (addr_i == DDR_ADDR);

  // A new key arriving in the same cycle as a KBDR read keeps ready set.
  always_comb begin
    ready_d    = ready_q;
    ie_d       = ie_q;
    kbd_data_d = kbd_data_q;
    if (access_i && we_i && (addr_i == KBSR_ADDR)) ie_d = wdata_i[14];
    if (access_i && !we_i && (addr_i == KBDR_ADDR)) ready_d = 1'b0;
    if (kbd_valid_i) begin
      ready_d    = 1'b1;
      kbd_data_d = kbd_data_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      KBSR_ADDR: rdata_o = {ready_q, ie_q, 14'h0};
      KBDR_ADDR: rdata_o = {8'h0, kbd_data_q};
      DSR_ADDR:  rdata_o = {dsp_ready_i, 15'h0};
      default:   rdata_o = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q     <= 1'b0;
      ie_q        <= 1'b0;
      kbd_data_q  <= '0;
      kbd_irq_o   <= 1'b0;
      dsp_valid_o <= 1'b0;
      dsp_data_o  <= '0;
    end else begin
      ready_q     <= ready_d;
      ie_q        <= ie_d;
      kbd_data_q  <= kbd_data_d;
      kbd_irq_o   <= ready_d & ie_d;
      dsp_valid_o <= ddr_wr;
      if (ddr_wr) dsp_data_o <= wdata_i[7:0];
    end
  end

endmodule
`endif

// File: rtl/lc3_mem_ctrl.sv
// Memory-access stage below lc3_control: one bus or local access per memEN request.
// Define LC3_MMIO_EN to decode the xFE00-xFE06 device registers locally.
module lc3_mem_ctrl
  import lc3_mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memEN,
  input  logic              memWE,
  input  logic [ADDR_W-1:0] MAR,
  input  logic [DATA_W-1:0] MDR,
  output logic [DATA_W-1:0] memOut,
  output logic              memRDY,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err
`ifdef LC3_MMIO_EN
  ,
  input  logic              kbd_valid,
  input  logic [7:0]        kbd_data,
  output logic              kbd_irq,
  input  logic              dsp_ready,
  output logic              dsp_valid,
  output logic [7:0]        dsp_data
`endif
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  mem_ctrl_states_e  state_q;
  logic [CntW-1:0]   cnt_q;
  logic              go_local;
  logic [DATA_W-1:0] local_rdata;

`ifdef LC3_MMIO_EN
  assign go_local = is_mmio(MAR);

  lc3_mmio_regs u_mmio (
    .clk         (clk),
    .rst         (rst),
    .access_i    (state_q == StLocal),
    .we_i        (bus_we),
    .addr_i      (bus_addr),
    .wdata_i     (bus_wdata),
    .kbd_valid_i (kbd_valid),
    .kbd_data_i  (kbd_data),
    .dsp_ready_i (dsp_ready),
    .rdata_o     (local_rdata),
    .kbd_irq_o   (kbd_irq),
    .dsp_valid_o (dsp_valid),
    .dsp_data_o  (dsp_data)
  );
`else
  assign go_local    = 1'b0;
  assign local_rdata = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      memRDY    <= 1'b0;
      memOut    <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      memRDY <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (memEN) begin
            bus_addr  <= MAR;
            bus_wdata <= MDR;
            bus_we    <= memWE;
            if (go_local) begin
              state_q <= StLocal;
            end else begin
              state_q <= StBus;
              bus_req <= 1'b1;
              cnt_q   <= '0;
            end
          end
        end
        StBus: begin
          // An ack on the final count still completes cleanly.
          if (bus_ack) begin
            if (!bus_we) memOut <= bus_rdata;
            bus_req <= 1'b0;
            memRDY  <= 1'b1;
            state_q <= StDone;
          end else if (cnt_q == CntLast) begin
            memOut  <= '0;
            bus_err <= 1'b1;
            bus_req <= 1'b0;
            memRDY  <= 1'b1;
            state_q <= StDone;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StLocal: begin
          if (!bus_we) memOut <= local_rdata;
          memRDY  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
